keypad_matrix_emulator: RTL

- Emulates a physical 4x4 membrane keypad at the fil/col pins. It responds to the column strobes from the keypad scanner by pulling the matching row low.
- Replays one keystroke per handshake: press bounce, stable hold, release bounce, then a quiet gap.
- Replaces the real keypad for on-board self-test and closed-loop simulation of the scan, debounce and display path at 27 MHz.

---
 rtl/keypad_matrix_emulator.sv | 199 +++++++++++++++++++
 1 files changed

// File: rtl/keypad_matrix_emulator.sv
// keypad_matrix_emulator: stands in for a 4x4 membrane keypad, replaying one
// keystroke (press bounce, hold, release bounce, quiet gap) per handshake.
// Ports: clk; rst (async, active-low); key_code/key_valid/key_ready request
//        handshake; col = scanner column drive (active-low); fil = row lines
//        back to the scanner (active-low, idle 1111); busy = keystroke in
//        progress; done = one-cycle pulse in the last cycle of a keystroke.
// Option: define KEYPAD_EMU_LFSR_BOUNCE_EN for pseudo-random contact bounce.
module keypad_matrix_emulator #(
   parameter int CNT_W         = 20,
   parameter int BOUNCE_CYCLES = 27000,
   parameter int BOUNCE_PERIOD = 2700,
   parameter int HOLD_CYCLES   = 540000,
   parameter int GAP_CYCLES    = 270000
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [3:0] key_code,
   input  logic       key_valid,
   output logic       key_ready,
   input  logic [3:0] col,
   output logic [3:0] fil,
   output logic       busy,
   output logic       done
);

   typedef enum logic [2:0] {
      IDLE,
      PRESS_B,
      HOLD,
      REL_B,
      GAP
   } state_t;

   localparam logic [CNT_W-1:0] BOUNCE_LAST = CNT_W'(BOUNCE_CYCLES - 1);
   localparam logic [CNT_W-1:0] HOLD_LAST   = CNT_W'(HOLD_CYCLES - 1);
   localparam logic [CNT_W-1:0] GAP_LAST    = CNT_W'(GAP_CYCLES - 1);

   // Key position of code 0 (row 3, column 1); the cleared latched code.
   localparam logic [3:0] POS_RST = 4'b11_01;

   state_t           state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [CNT_W-1:0] ph_q, ph_d, ph_step;
   logic             contact_q, contact_d;
   logic [3:0]       pos_q, pos_d;
   logic             busy_q, busy_d;
   logic             done_q, done_d;
   logic             toggle;

   // Code -> {row, column}. The position pair is what gets latched; it
   // identifies the code one-to-one.
   function automatic logic [3:0] key_pos(input logic [3:0] k);
      logic [3:0] p;
      case (k)
         4'h1:    p = 4'b00_00;
         4'h2:    p = 4'b00_01;
         4'h3:    p = 4'b00_10;
         4'hA:    p = 4'b00_11;
         4'h4:    p = 4'b01_00;
         4'h5:    p = 4'b01_01;
         4'h6:    p = 4'b01_10;
         4'hB:    p = 4'b01_11;
         4'h7:    p = 4'b10_00;
         4'h8:    p = 4'b10_01;
         4'h9:    p = 4'b10_10;
         4'hC:    p = 4'b10_11;
         4'hE:    p = 4'b11_00;
         4'h0:    p = 4'b11_01;
         4'hF:    p = 4'b11_10;
         default: p = 4'b11_11;
      endcase
      return p;
   endfunction

`ifdef KEYPAD_EMU_LFSR_BOUNCE_EN
   localparam logic [CNT_W-1:0] MIN_GAP = CNT_W'(BOUNCE_PERIOD / 4);

   logic [15:0] lfsr_q, lfsr_d;

   // ph_q counts cycles since the last toggle, saturating once the minimum
   // spacing has been reached.
   always_comb begin
      lfsr_d  = {lfsr_q[0] ^ lfsr_q[2] ^ lfsr_q[3] ^ lfsr_q[5],
                 lfsr_q[15:1]};
      toggle  = lfsr_q[0] && (ph_q >= MIN_GAP);
      ph_step = ph_q;
      if (toggle) begin
         ph_step = '0;
      end else if (ph_q < MIN_GAP) begin
         ph_step = ph_q + 1'b1;
      end
   end
`else
   localparam logic [CNT_W-1:0] PERIOD_LAST = CNT_W'(BOUNCE_PERIOD - 1);

   // ph_q counts cycles within the current toggle period.
   always_comb begin
      toggle  = (ph_q == PERIOD_LAST);
      ph_step = toggle ? '0 : ph_q + 1'b1;
   end
`endif

   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q + 1'b1;
      ph_d      = '0;
      contact_d = contact_q;
      pos_d     = pos_q;
      unique case (state_q)
         IDLE: begin
            cnt_d     = '0;
            contact_d = 1'b0;
            if (key_valid && key_ready) begin
               state_d   = PRESS_B;
               pos_d     = key_pos(key_code);
               contact_d = 1'b1;
            end
         end
         PRESS_B: begin
            if (cnt_q == BOUNCE_LAST) begin
               state_d   = HOLD;
               cnt_d     = '0;
               contact_d = 1'b1;
            end else begin
               ph_d = ph_step;
               if (toggle) contact_d = ~contact_q;
            end
         end
         HOLD: begin
            if (cnt_q == HOLD_LAST) begin
               state_d   = REL_B;
               cnt_d     = '0;
               contact_d = 1'b0;
            end
         end
         REL_B: begin
            if (cnt_q == BOUNCE_LAST) begin
               state_d   = GAP;
               cnt_d     = '0;
               contact_d = 1'b0;
            end else begin
               ph_d = ph_step;
               if (toggle) contact_d = ~contact_q;
            end
         end
         GAP: begin
            contact_d = 1'b0;
            if (cnt_q == GAP_LAST) begin
               state_d = IDLE;
               cnt_d   = '0;
            end
         end
         default: begin
            state_d   = IDLE;
            cnt_d     = '0;
            contact_d = 1'b0;
         end
      endcase
      busy_d = (state_d != IDLE);
      done_d = (state_d == GAP) && (cnt_d == GAP_LAST);
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q   <= IDLE;
         cnt_q     <= '0;
         ph_q      <= '0;
         contact_q <= 1'b0;
         pos_q     <= POS_RST;
         busy_q    <= 1'b0;
         done_q    <= 1'b0;
`ifdef KEYPAD_EMU_LFSR_BOUNCE_EN
         lfsr_q    <= 16'hACE1;
`endif
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         ph_q      <= ph_d;
         contact_q <= contact_d;
         pos_q     <= pos_d;
         busy_q    <= busy_d;
         done_q    <= done_d;
`ifdef KEYPAD_EMU_LFSR_BOUNCE_EN
         lfsr_q    <= lfsr_d;
`endif
      end
   end

   // Matrix path: combinational from col, like a real membrane contact.
   always_comb begin
      fil = 4'hF;
      if (contact_q && !col[pos_q[1:0]]) fil[pos_q[3:2]] = 1'b0;
   end

   assign key_ready = ~busy_q;
   assign busy      = busy_q;
   assign done      = done_q;

endmodule
